// File: rtl/hue_seq_pkg.sv
// Hue-wheel phase encoding and the (phase, step) -> RGB duty decode shared by the sequencer.
// Pure combinational helpers; no latency, no flow control.
package hue_seq_pkg;

    localparam int unsigned NUM_PHASES = 6;

    typedef enum logic [2:0] {
        PH_G_UP = 3'd0,
        PH_R_DN = 3'd1,
        PH_B_UP = 3'd2,
        PH_G_DN = 3'd3,
        PH_R_UP = 3'd4,
        PH_B_DN = 3'd5
    } hue_phase_t;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
    } duty_t;

    // One channel ramps per phase while the other two sit at a rail, so
    // neighbouring (p, s) points always differ in exactly one channel.
    function automatic duty_t hue_duty(
        input logic [2:0]  p,
        input logic [31:0] s,
        input logic [31:0] inc,
        input logic [31:0] pwm
    );
        logic [31:0] up;
        logic [31:0] dn;
        duty_t       d;
        up  = inc * s;
        dn  = pwm - up;
        d.r = pwm;
        d.g = 32'd0;
        d.b = 32'd0;
        case (hue_phase_t'(p))
            PH_G_UP: begin d.r = pwm;   d.g = up;    d.b = 32'd0; end
            PH_R_DN: begin d.r = dn;    d.g = pwm;   d.b = 32'd0; end
            PH_B_UP: begin d.r = 32'd0; d.g = pwm;   d.b = up;    end
            PH_G_DN: begin d.r = 32'd0; d.g = dn;    d.b = pwm;   end
            PH_R_UP: begin d.r = up;    d.g = 32'd0; d.b = pwm;   end
            PH_B_DN: begin d.r = pwm;   d.g = 32'd0; d.b = dn;    end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hue_sequencer_step_timer.sv
// step_timer: counts run-gated clocks and strobes o_step on the last tick of each step.
// Strobe is combinational from the registered tick; run=0 freezes the count in place.
module step_timer #(
    parameter int STEP_CLKS = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_step
);

    localparam int TW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;

    logic [TW-1:0] r_tick;
    logic          w_last;

    assign w_last = (r_tick == TW'(STEP_CLKS - 1));
    assign o_step = i_run && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
        end else if (i_run) begin
            if (w_last) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// hue_sequencer: drives R/G/B pwm duty through a colour-wheel fade; duties are registered at each step event.
// run=0 freezes everything; define HUE_SEQUENCER_DIR_EN to add the dir input for reverse sequencing.
module hue_sequencer
    import hue_seq_pkg::*;
#(
    parameter int PWM_INTERVAL    = 1200,
    parameter int STEPS_PER_PHASE = 200,
    parameter int STEP_CLKS       = 10000
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              run,
`ifdef HUE_SEQUENCER_DIR_EN
    input  logic                              dir,
`endif
    output logic [$clog2(PWM_INTERVAL+1)-1:0] dc_r,
    output logic [$clog2(PWM_INTERVAL+1)-1:0] dc_g,
    output logic [$clog2(PWM_INTERVAL+1)-1:0] dc_b,
    output logic [2:0]                        phase,
    output logic                              cycle_done
);

    localparam int DW  = $clog2(PWM_INTERVAL + 1);
    localparam int SW  = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
    localparam int INC = (STEPS_PER_PHASE > 0) ? PWM_INTERVAL / STEPS_PER_PHASE : 0;

    if (STEPS_PER_PHASE < 1 || (PWM_INTERVAL % STEPS_PER_PHASE) != 0) begin : g_bad_steps
        $error("hue_sequencer: STEPS_PER_PHASE must divide PWM_INTERVAL exactly");
    end
    if (STEP_CLKS < 1) begin : g_bad_clks
        $error("hue_sequencer: STEP_CLKS must be at least 1");
    end

    logic          w_step;
    logic          w_dir;
    logic [SW-1:0] r_s;
    logic [2:0]    r_p;
    logic [SW-1:0] w_s_nxt;
    logic [2:0]    w_p_nxt;
    logic          w_wrap;
    duty_t         w_duty;
    logic [DW-1:0] r_dc_r;
    logic [DW-1:0] r_dc_g;
    logic [DW-1:0] r_dc_b;
    logic          r_cycle_done;
    logic          w_unused;

`ifdef HUE_SEQUENCER_DIR_EN
    assign w_dir = dir;
`else
    assign w_dir = 1'b0;
`endif

    step_timer #(
        .STEP_CLKS (STEP_CLKS)
    ) u_step_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (run),
        .o_step (w_step)
    );

    always_comb begin
        w_s_nxt = r_s;
        w_p_nxt = r_p;
        w_wrap  = 1'b0;
        if (!w_dir) begin
            if (r_s == SW'(STEPS_PER_PHASE - 1)) begin
                w_s_nxt = '0;
                if (r_p == 3'(NUM_PHASES - 1)) begin
                    w_p_nxt = 3'd0;
                    w_wrap  = 1'b1;
                end else begin
                    w_p_nxt = r_p + 3'd1;
                end
            end else begin
                w_s_nxt = r_s + 1'b1;
            end
        end else begin
            if (r_s == '0) begin
                w_s_nxt = SW'(STEPS_PER_PHASE - 1);
                if (r_p == 3'd0) begin
                    w_p_nxt = 3'(NUM_PHASES - 1);
                    w_wrap  = 1'b1;
                end else begin
                    w_p_nxt = r_p - 3'd1;
                end
            end else begin
                w_s_nxt = r_s - 1'b1;
            end
        end
    end

    // Decode the post-step point so the registered duties always equal f(p, s).
    assign w_duty = hue_duty(w_p_nxt, 32'(w_s_nxt), 32'(INC), 32'(PWM_INTERVAL));

    assign w_unused = ^{w_duty.r[31:DW], w_duty.g[31:DW], w_duty.b[31:DW]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s          <= '0;
            r_p          <= 3'd0;
            r_dc_r       <= DW'(PWM_INTERVAL);
            r_dc_g       <= '0;
            r_dc_b       <= '0;
            r_cycle_done <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            if (w_step) begin
                r_s          <= w_s_nxt;
                r_p          <= w_p_nxt;
                r_dc_r       <= w_duty.r[DW-1:0];
                r_dc_g       <= w_duty.g[DW-1:0];
                r_dc_b       <= w_duty.b[DW-1:0];
                r_cycle_done <= w_wrap;
            end
        end
    end

    assign dc_r       = r_dc_r;
    assign dc_g       = r_dc_g;
    assign dc_b       = r_dc_b;
    assign phase      = r_p;
    assign cycle_done = r_cycle_done;

endmodule
